// File: rtl/bus_timer_slave_if.sv
// bus_timer_slave_if: valid/ready request bus between the arbiter port and the timer.
// Signals: s_valid_i/s_addr_i/s_wdata_i/s_we_i driven by the initiator,
// s_ready_o/s_rdata_o driven by the responder. s_we_i==0 means read.
interface bus_timer_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
);
  logic                  s_valid_i;
  logic                  s_ready_o;
  logic [ADDR_WIDTH-1:0] s_addr_i;
  logic [WORD_WIDTH-1:0] s_wdata_i;
  logic [3:0]            s_we_i;
  logic [WORD_WIDTH-1:0] s_rdata_o;
  modport master (output s_valid_i, s_addr_i, s_wdata_i, s_we_i, input s_ready_o, s_rdata_o);
  modport slave  (input s_valid_i, s_addr_i, s_wdata_i, s_we_i, output s_ready_o, s_rdata_o);
endinterface

// File: rtl/bus_timer_slave.sv
// bus_timer_slave: memory-mapped 64-bit machine timer with prescaler, compare and interrupt.
// Ports: clk, rst_n (async, active low), bus (slave modport of bus_timer_slave_if),
// irq_o (registered level interrupt = IRQ_EN & (mtime >= mtimecmp), one cycle late).
module bus_timer_slave #(
  parameter int ADDR_WIDTH     = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  bus_timer_slave_if.slave   bus,
  output logic               irq_o
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t                    state_q, state_d;
  logic                      ready_q, ready_d;
  logic [WORD_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      irq_q, irq_d;
  logic [63:0]               mtime_q, mtime_d;
  logic [63:0]               mtimecmp_q, mtimecmp_d;
  logic [1:0]                ctrl_q, ctrl_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]               hi_shadow_q, hi_shadow_d;
  logic                      req, wr, rd, tick, status;
  logic [2:0]                sel;
  logic [63:0]               inc;
  logic [31:0]               rmux;
  logic                      unused_addr;
  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    for (int i = 0; i < 4; i++) mrg[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
  endfunction
  assign unused_addr = ^{bus.s_addr_i[ADDR_WIDTH-1:5], bus.s_addr_i[1:0]};
  always_comb begin
    req    = (state_q == IDLE) && bus.s_valid_i;
    wr     = req && (bus.s_we_i != 4'd0);
    rd     = req && (bus.s_we_i == 4'd0);
    sel    = bus.s_addr_i[4:2];
    status = mtime_q >= mtimecmp_q;
    tick   = ctrl_q[0] && (cnt_q == '0);
    inc    = mtime_q + 64'(tick);
    // A LO write discards the carry into HI; a HI write keeps LO's own increment.
    mtime_d = (wr && sel == 3'd0) ? {mtime_q[63:32], mrg(inc[31:0], bus.s_wdata_i, bus.s_we_i)} :
              (wr && sel == 3'd1) ? {mrg(inc[63:32], bus.s_wdata_i, bus.s_we_i), inc[31:0]} : inc;
    mtimecmp_d = (wr && sel == 3'd2) ? {mtimecmp_q[63:32], mrg(mtimecmp_q[31:0], bus.s_wdata_i, bus.s_we_i)} :
                 (wr && sel == 3'd3) ? {mrg(mtimecmp_q[63:32], bus.s_wdata_i, bus.s_we_i), mtimecmp_q[31:0]} : mtimecmp_q;
    ctrl_d     = (wr && sel == 3'd4) ? 2'(mrg(32'(ctrl_q), bus.s_wdata_i, bus.s_we_i)) : ctrl_q;
    prescale_d = (wr && sel == 3'd5) ? PRESCALE_WIDTH'(mrg(32'(prescale_q), bus.s_wdata_i, bus.s_we_i)) : prescale_q;
    // New PRESCALE values are only picked up at the next reload.
    cnt_d = !ctrl_q[0] ? cnt_q : (cnt_q == '0) ? prescale_q : cnt_q - 1'b1;
    case (sel)
      3'd0:    rmux = mtime_q[31:0];
      3'd1:    rmux = hi_shadow_q;
      3'd2:    rmux = mtimecmp_q[31:0];
      3'd3:    rmux = mtimecmp_q[63:32];
      3'd4:    rmux = {30'd0, ctrl_q};
      3'd5:    rmux = 32'(prescale_q);
      3'd6:    rmux = {31'd0, status};
      default: rmux = 32'd0;
    endcase
    rdata_d     = rd ? WORD_WIDTH'(rmux) : rdata_q;
    hi_shadow_d = (rd && sel == 3'd0) ? mtime_q[63:32] : hi_shadow_q;
    irq_d       = ctrl_q[1] && status;
    ready_d     = req;
    state_d     = req ? RESP : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      ctrl_q      <= '0;
      prescale_q  <= '0;
      cnt_q       <= '0;
      hi_shadow_q <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      ctrl_q      <= ctrl_d;
      prescale_q  <= prescale_d;
      cnt_q       <= cnt_d;
      hi_shadow_q <= hi_shadow_d;
    end
  end
  assign bus.s_ready_o = ready_q;
  assign bus.s_rdata_o = rdata_q;
  assign irq_o         = irq_q;
endmodule

// File: tb/tb_bus_timer_slave.sv
// tb_bus_timer_slave: directed test-plan sequences plus random traffic against a reference model.
module tb_bus_timer_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic irq;
  int   n_cmp = 0;
  int   n_err = 0;
  bus_timer_slave_if bus ();
  bus_timer_slave dut (.clk(clk), .rst_n(rst_n), .bus(bus), .irq_o(irq));
  always #5 clk = ~clk;
  logic [63:0] m_time, m_cmp;
  logic        m_en, m_ie, m_rdy, m_irq;
  logic [15:0] m_ps, m_cnt;
  logic [31:0] m_sh, m_rd;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] bmrg(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (nw & m);
  endfunction
  task automatic m_reset();
    m_time = 0; m_cmp = '1; m_en = 0; m_ie = 0; m_ps = 0; m_cnt = 0;
    m_sh = 0; m_rd = 0; m_rdy = 0; m_irq = 0;
  endtask
  task automatic m_edge(input logic v, input logic [2:0] sel, input logic [3:0] we, input logic [31:0] wd);
    logic        acc, tick, irq_nx;
    logic [63:0] nxt;
    logic [31:0] t;
    acc    = v && !m_rdy;
    tick   = m_en && m_cnt == 0;
    nxt    = m_time + (tick ? 64'd1 : 64'd0);
    irq_nx = m_ie && (m_time >= m_cmp);
    if (acc && we == 0) begin
      case (sel)
        0: m_rd = m_time[31:0];
        1: m_rd = m_sh;
        2: m_rd = m_cmp[31:0];
        3: m_rd = m_cmp[63:32];
        4: m_rd = {30'd0, m_ie, m_en};
        5: m_rd = {16'd0, m_ps};
        6: m_rd = (m_time >= m_cmp) ? 32'd1 : 32'd0;
        default: m_rd = 0;
      endcase
      if (sel == 0) m_sh = m_time[63:32];
    end
    if (m_en) m_cnt = (m_cnt == 0) ? m_ps : m_cnt - 16'd1;
    if (acc && we != 0) begin
      case (sel)
        0: nxt = {m_time[63:32], bmrg(nxt[31:0], wd, we)};
        1: nxt[63:32] = bmrg(nxt[63:32], wd, we);
        2: m_cmp[31:0] = bmrg(m_cmp[31:0], wd, we);
        3: m_cmp[63:32] = bmrg(m_cmp[63:32], wd, we);
        4: if (we[0]) {m_ie, m_en} = wd[1:0];
        5: begin t = bmrg({16'd0, m_ps}, wd, we); m_ps = t[15:0]; end
        default: ;
      endcase
    end
    m_time = nxt;
    m_rdy  = acc;
    m_irq  = irq_nx;
  endtask
  task automatic cyc(input logic v, input logic [2:0] sel, input logic [3:0] we, input logic [31:0] wd);
    logic [31:0] a;
    a = $urandom;
    a[4:2] = sel;
    a[1:0] = 2'd0;
    bus.s_valid_i = v; bus.s_addr_i = a; bus.s_we_i = we; bus.s_wdata_i = wd;
    @(posedge clk);
    m_edge(v, sel, we, wd);
    @(negedge clk);
    chk("ready", 64'(bus.s_ready_o), 64'(m_rdy));
    chk("rdata", 64'(bus.s_rdata_o), 64'(m_rd));
    chk("irq", 64'(irq), 64'(m_irq));
  endtask
  task automatic wr(input logic [2:0] sel, input logic [3:0] we, input logic [31:0] wd);
    cyc(1, sel, we, wd);
    cyc(0, 0, 0, 0);
  endtask
  task automatic rd(input logic [2:0] sel, output logic [31:0] d);
    cyc(1, sel, 0, 0);
    d = bus.s_rdata_o;
    cyc(0, 0, 0, 0);
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    bus.s_valid_i = 1'b0;
    #1;
    chk("rst_ready", 64'(bus.s_ready_o), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_rdata", 64'(bus.s_rdata_o), 64'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [31:0] v, hi;
    logic [5:0]  pat;
    logic [2:0]  s;
    logic [3:0]  we;
    logic [31:0] wd;
    bus.s_valid_i = 0; bus.s_addr_i = 0; bus.s_we_i = 0; bus.s_wdata_i = 0;
    m_reset();
    @(negedge clk);
    do_reset();
    cyc(1, 4, 0, 0);
    chk("first_ready", 64'(bus.s_ready_o), 64'd1);
    chk("ctrl_reset", 64'(bus.s_rdata_o), 64'd0);
    cyc(0, 0, 0, 0);
    chk("ready_drop", 64'(bus.s_ready_o), 64'd0);
    rd(3, v);
    chk("cmp_hi_reset", 64'(v), 64'hFFFF_FFFF);
    do_reset();
    wr(5, 4'hF, 32'd3);
    wr(4, 4'hF, 32'd1);
    idle(40);
    rd(0, v);
    chk("prescale_rate", 64'(v >= 9 && v <= 12), 64'd1);
    do_reset();
    wr(0, 4'hF, 32'hFFFF_FFFF);
    wr(1, 4'hF, 32'd0);
    wr(5, 4'hF, 32'd0);
    wr(4, 4'hF, 32'd1);
    rd(0, v);
    idle(3);
    rd(1, hi);
    chk("wrap_hi", 64'(hi), 64'd1);
    do_reset();
    wr(2, 4'hF, 32'd20);
    wr(3, 4'hF, 32'd0);
    wr(4, 4'hF, 32'd3);
    idle(30);
    rd(6, v);
    chk("status_set", 64'(v), 64'd1);
    chk("irq_set", 64'(irq), 64'd1);
    wr(2, 4'hF, 32'd1000);
    chk("irq_clear", 64'(irq), 64'd0);
    wr(2, 4'hF, 32'd20);
    wr(4, 4'hF, 32'd1);
    idle(3);
    rd(6, v);
    chk("status_noirq", 64'(v), 64'd1);
    chk("irq_masked", 64'(irq), 64'd0);
    do_reset();
    wr(2, 4'b0010, 32'hAABB_CCDD);
    rd(2, v);
    chk("byte_en", 64'(v), 64'hFFFF_CCFF);
    wr(7, 4'hF, 32'h1234_5678);
    rd(7, v);
    chk("unmapped", 64'(v), 64'd0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1, 4, 0, 0);
      pat[i] = bus.s_ready_o;
    end
    chk("hold_pattern", 64'(pat), 64'(6'b010101));
    cyc(1, 4, 0, 0);
    do_reset();
    cyc(1, 4, 0, 0);
    chk("post_rst_ready", 64'(bus.s_ready_o), 64'd1);
    cyc(0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      s  = 3'($urandom_range(0, 7));
      we = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      wd = $urandom;
      if (s == 5) wd = $urandom_range(0, 3);
      if (s == 3 && $urandom_range(0, 1) == 0) wd = m_time[63:32];
      if (s == 2 && $urandom_range(0, 1) == 0) wd = m_time[31:0] + $urandom_range(0, 40);
      if (s == 0 && $urandom_range(0, 3) == 0) wd = 32'hFFFF_FFF0 | $urandom_range(0, 15);
      cyc($urandom_range(0, 9) < 7, s, we, wd);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
